// File: rtl/ft_245_pkg.sv
// Shared definitions for the FT245 FIFO responder: one-hot FSM encodings,
// default depths / precharge lengths and the statistics counter width.
package ft_245_pkg;

  // Bit positions of each state inside the one-hot vectors (same order as the controller).
  localparam int R_IDLE_IDX      = 0;
  localparam int R_DRIVE_IDX     = 1;
  localparam int R_PRECHARGE_IDX = 2;
  localparam int W_IDLE_IDX      = 0;
  localparam int W_CAPTURE_IDX   = 1;
  localparam int W_PRECHARGE_IDX = 2;

  typedef enum logic [2:0] {
    R_IDLE      = 3'b001,
    R_DRIVE     = 3'b010,
    R_PRECHARGE = 3'b100
  } rd_state_e;

  typedef enum logic [2:0] {
    W_IDLE      = 3'b001,
    W_CAPTURE   = 3'b010,
    W_PRECHARGE = 3'b100
  } wr_state_e;

  localparam int DEF_RX_DEPTH      = 16;
  localparam int DEF_TX_DEPTH      = 16;
  localparam int DEF_RXF_PRECHARGE = 2;
  localparam int DEF_TXE_PRECHARGE = 2;

  // Statistics counter width and precharge counter width (precharge is 1..15).
  localparam int CNT_W     = 16;
  localparam int PRE_CNT_W = 4;

  // Statistics counters wrap naturally from all-ones back to zero.
  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
    return c + 1'b1;
  endfunction

endpackage

// File: rtl/ft_245_fifo_responder_if.sv
// FT245 pin bundle. The controller (FPGA side) uses the master modport,
// the responder (USB-chip side) uses the slave modport.
interface ft_245_fifo_responder_if;
  logic       USB_RD_N;
  logic       USB_WR;
  logic [7:0] USB_DATA_IN;
  logic [7:0] USB_DATA_OUT;
  logic       USB_DATA_OUT_EN;
  logic       USB_RXF_N;
  logic       USB_TXE_N;

  modport master (
    output USB_RD_N, USB_WR, USB_DATA_IN,
    input  USB_DATA_OUT, USB_DATA_OUT_EN, USB_RXF_N, USB_TXE_N
  );

  modport slave (
    input  USB_RD_N, USB_WR, USB_DATA_IN,
    output USB_DATA_OUT, USB_DATA_OUT_EN, USB_RXF_N, USB_TXE_N
  );
endinterface

// File: rtl/ft_245_byte_fifo.sv
// Synchronous 8-bit FIFO. A push and a pop in the same cycle are both
// performed even when full or empty, so occupancy is left unchanged.
module ft_245_byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic       full,
  output logic       empty,
  output logic [7:0] head
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign empty = (cnt_q == '0);
  assign head  = mem_q[rp_q];

  // Qualify push/pop and advance pointers and occupancy.
  always_comb begin
    do_push = push & (~full | pop);
    do_pop  = pop & (~empty | push);
    wp_d    = wp_q + AW'(do_push);
    rp_d    = rp_q + AW'(do_pop);
    cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  // Pointer and occupancy state; reset flushes the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  // Byte storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q] <= din;
  end
endmodule

// File: rtl/ft_245_fifo_responder.sv
// FT245 asynchronous FIFO responder: plays the USB-chip side of the bus.
// Optional statistics counters are enabled by defining FT245_RESP_STATS_EN.
module ft_245_fifo_responder
  import ft_245_pkg::*;
#(
  parameter int RX_DEPTH      = DEF_RX_DEPTH,
  parameter int TX_DEPTH      = DEF_TX_DEPTH,
  parameter int RXF_PRECHARGE = DEF_RXF_PRECHARGE,
  parameter int TXE_PRECHARGE = DEF_TXE_PRECHARGE
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  ft_245_fifo_responder_if.slave usb,
  input  logic                   HOST_WR_EN,
  input  logic [7:0]             HOST_WR_BYTE,
  output logic                   HOST_WR_READY,
  input  logic                   HOST_RD_EN,
  output logic [7:0]             HOST_RD_BYTE,
  output logic                   HOST_RD_VALID,
  output logic                   PROTO_ERR,
  output logic [CNT_W-1:0]       RD_COUNT,
  output logic [CNT_W-1:0]       WR_COUNT
);
  localparam logic [PRE_CNT_W-1:0] RXF_LAST = PRE_CNT_W'(RXF_PRECHARGE - 1);
  localparam logic [PRE_CNT_W-1:0] TXE_LAST = PRE_CNT_W'(TXE_PRECHARGE - 1);

  logic                 rd_q, rd_d, wr_q, wr_d;
  logic                 rd_fall, rd_rise, wr_fall, wr_rise;
  rd_state_e            rd_state_q, rd_state_d;
  wr_state_e            wr_state_q, wr_state_d;
  logic [7:0]           dout_q, dout_d;
  logic                 dout_en_q, dout_en_d;
  logic                 rxf_n_q, rxf_n_d, txe_n_q, txe_n_d;
  logic                 rd_valid_q, rd_valid_d;
  logic [PRE_CNT_W-1:0] rd_pre_q, rd_pre_d, wr_pre_q, wr_pre_d;
  logic                 proto_err_q, proto_err_d;
  logic                 rd_err, wr_err, rx_pop, tx_push;
  logic                 rx_full, rx_empty, tx_full, tx_empty;
  logic [7:0]           rx_head, tx_head;

  ft_245_byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(CLK), .rst_n(RST_N), .push(HOST_WR_EN), .din(HOST_WR_BYTE), .pop(rx_pop),
    .full(rx_full), .empty(rx_empty), .head(rx_head)
  );

  ft_245_byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(CLK), .rst_n(RST_N), .push(tx_push), .din(usb.USB_DATA_IN), .pop(HOST_RD_EN),
    .full(tx_full), .empty(tx_empty), .head(tx_head)
  );

  assign HOST_WR_READY       = ~rx_full;
  assign HOST_RD_VALID       = ~tx_empty;
  assign HOST_RD_BYTE        = tx_head;
  assign PROTO_ERR           = proto_err_q;
  assign usb.USB_DATA_OUT    = dout_q;
  assign usb.USB_DATA_OUT_EN = dout_en_q;
  assign usb.USB_RXF_N       = rxf_n_q;
  assign usb.USB_TXE_N       = txe_n_q;

  // Strobe edges: raw pin against its registered copy.
  always_comb begin
    rd_d    = usb.USB_RD_N;
    wr_d    = usb.USB_WR;
    rd_fall = rd_q & ~usb.USB_RD_N;
    rd_rise = ~rd_q & usb.USB_RD_N;
    wr_fall = wr_q & ~usb.USB_WR;
    wr_rise = ~wr_q & usb.USB_WR;
  end

  // Read FSM: present the RX head while RD_N is low, pop it when RD_N rises.
  always_comb begin
    rd_state_d = rd_state_q;
    dout_d     = dout_q;
    dout_en_d  = dout_en_q;
    rxf_n_d    = rxf_n_q;
    rd_valid_d = rd_valid_q;
    rd_pre_d   = rd_pre_q;
    rd_err     = 1'b0;
    rx_pop     = 1'b0;
    case (rd_state_q)
      R_IDLE: begin
        rxf_n_d = rx_empty;
        if (rd_fall) begin
          dout_en_d  = 1'b1;
          rd_state_d = R_DRIVE;
          if (!rx_empty) begin
            dout_d     = rx_head;
            rd_valid_d = 1'b1;
            rxf_n_d    = 1'b0;
          end else begin
            // Read of an empty FIFO: drive a null byte and flag it.
            dout_d     = 8'h00;
            rd_valid_d = 1'b0;
            rxf_n_d    = 1'b1;
            rd_err     = 1'b1;
          end
        end
      end
      R_DRIVE: begin
        rxf_n_d = ~rd_valid_q;
        if (rd_rise) begin
          rx_pop     = rd_valid_q;
          rd_valid_d = 1'b0;
          dout_en_d  = 1'b0;
          rxf_n_d    = 1'b1;
          rd_pre_d   = '0;
          rd_state_d = R_PRECHARGE;
        end
      end
      R_PRECHARGE: begin
        rxf_n_d = 1'b1;
        if (rd_pre_q == RXF_LAST) begin
          rd_state_d = R_IDLE;
          rxf_n_d    = rx_empty;
        end else begin
          rd_pre_d = rd_pre_q + 1'b1;
        end
      end
      default: begin
        rd_state_d = R_IDLE;
        rxf_n_d    = 1'b1;
      end
    endcase
  end

  // Write FSM: capture the pin byte on the WR falling edge, then precharge TXE_N.
  always_comb begin
    wr_state_d = wr_state_q;
    txe_n_d    = txe_n_q;
    wr_pre_d   = wr_pre_q;
    wr_err     = 1'b0;
    tx_push    = 1'b0;
    case (wr_state_q)
      W_IDLE: begin
        txe_n_d = tx_full;
        if (wr_fall) begin
          txe_n_d    = 1'b1;
          wr_state_d = W_CAPTURE;
          if (!tx_full) tx_push = 1'b1;
          else          wr_err  = 1'b1;
        end
      end
      W_CAPTURE: begin
        txe_n_d = 1'b1;
        if (wr_rise) begin
          wr_pre_d   = '0;
          wr_state_d = W_PRECHARGE;
        end
      end
      W_PRECHARGE: begin
        txe_n_d = 1'b1;
        if (wr_pre_q == TXE_LAST) begin
          wr_state_d = W_IDLE;
          txe_n_d    = tx_full;
        end else begin
          wr_pre_d = wr_pre_q + 1'b1;
        end
      end
      default: begin
        wr_state_d = W_IDLE;
        txe_n_d    = 1'b1;
      end
    endcase
    proto_err_d = proto_err_q | rd_err | wr_err;
  end

  // Control and pin-output registers; reset aborts any transfer in flight.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rd_q        <= 1'b1;
      wr_q        <= 1'b1;
      rd_state_q  <= R_IDLE;
      wr_state_q  <= W_IDLE;
      dout_q      <= 8'h00;
      dout_en_q   <= 1'b0;
      rxf_n_q     <= 1'b1;
      txe_n_q     <= 1'b1;
      rd_valid_q  <= 1'b0;
      rd_pre_q    <= '0;
      wr_pre_q    <= '0;
      proto_err_q <= 1'b0;
    end else begin
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      rd_state_q  <= rd_state_d;
      wr_state_q  <= wr_state_d;
      dout_q      <= dout_d;
      dout_en_q   <= dout_en_d;
      rxf_n_q     <= rxf_n_d;
      txe_n_q     <= txe_n_d;
      rd_valid_q  <= rd_valid_d;
      rd_pre_q    <= rd_pre_d;
      wr_pre_q    <= wr_pre_d;
      proto_err_q <= proto_err_d;
    end
  end

`ifdef FT245_RESP_STATS_EN
  logic [CNT_W-1:0] rd_count_q, rd_count_d, wr_count_q, wr_count_d;

  // Count bytes actually moved over the pins.
  always_comb begin
    rd_count_d = rx_pop  ? cnt_inc(rd_count_q) : rd_count_q;
    wr_count_d = tx_push ? cnt_inc(wr_count_q) : wr_count_q;
  end

  // Statistics registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else begin
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign RD_COUNT = rd_count_q;
  assign WR_COUNT = wr_count_q;
`else
  assign RD_COUNT = '0;
  assign WR_COUNT = '0;
`endif

endmodule

// File: tb/tb_ft_245_fifo_responder.sv
// Bench for ft_245_fifo_responder: directed scenarios plus a random mix of
// host pushes/pops and pin reads/writes against a queue-based reference model.
module tb_ft_245_fifo_responder;
  localparam int DEPTH = 16;
  localparam int PRE   = 2;
`ifdef FT245_RESP_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST_N = 1'b1;
  logic        HOST_WR_EN = 1'b0;
  logic [7:0]  HOST_WR_BYTE = 8'h00;
  logic        HOST_WR_READY;
  logic        HOST_RD_EN = 1'b0;
  logic [7:0]  HOST_RD_BYTE;
  logic        HOST_RD_VALID;
  logic        PROTO_ERR;
  logic [15:0] RD_COUNT, WR_COUNT;

  ft_245_fifo_responder_if usb_if ();

  ft_245_fifo_responder dut (
    .CLK(CLK), .RST_N(RST_N), .usb(usb_if),
    .HOST_WR_EN(HOST_WR_EN), .HOST_WR_BYTE(HOST_WR_BYTE), .HOST_WR_READY(HOST_WR_READY),
    .HOST_RD_EN(HOST_RD_EN), .HOST_RD_BYTE(HOST_RD_BYTE), .HOST_RD_VALID(HOST_RD_VALID),
    .PROTO_ERR(PROTO_ERR), .RD_COUNT(RD_COUNT), .WR_COUNT(WR_COUNT)
  );

  always #5 CLK = ~CLK;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model state.
  logic [7:0] rx_m[$];
  logic [7:0] tx_m[$];
  bit         perr_m = 1'b0;
  int         rdc_m = 0;
  int         wrc_m = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge CLK);
  endtask

  task automatic chk_counts();
    chk("rd_count", RD_COUNT, STATS ? 16'(rdc_m) : 16'h0);
    chk("wr_count", WR_COUNT, STATS ? 16'(wrc_m) : 16'h0);
  endtask

  task automatic apply_reset();
    RST_N = 1'b0;
    usb_if.USB_RD_N = 1'b1;
    usb_if.USB_WR = 1'b1;
    HOST_WR_EN = 1'b0;
    HOST_RD_EN = 1'b0;
    #1;
    chk("rst_rxf_n", usb_if.USB_RXF_N, 1'b1);
    chk("rst_txe_n", usb_if.USB_TXE_N, 1'b1);
    chk("rst_dout_en", usb_if.USB_DATA_OUT_EN, 1'b0);
    chk("rst_dout", usb_if.USB_DATA_OUT, 8'h00);
    chk("rst_proto_err", PROTO_ERR, 1'b0);
    chk("rst_wr_ready", HOST_WR_READY, 1'b1);
    chk("rst_rd_valid", HOST_RD_VALID, 1'b0);
    rx_m.delete();
    tx_m.delete();
    perr_m = 1'b0;
    rdc_m = 0;
    wrc_m = 0;
    chk_counts();
    @(negedge CLK);
    tick();
    RST_N = 1'b1;
    tick();
    chk("rel_txe_n", usb_if.USB_TXE_N, 1'b0);
    chk("rel_rxf_n", usb_if.USB_RXF_N, 1'b1);
  endtask

  task automatic host_push(input logic [7:0] b);
    chk("wr_ready", HOST_WR_READY, rx_m.size() < DEPTH);
    HOST_WR_EN = 1'b1;
    HOST_WR_BYTE = b;
    tick();
    HOST_WR_EN = 1'b0;
    if (rx_m.size() < DEPTH) rx_m.push_back(b);
  endtask

  task automatic host_pop();
    chk("rd_valid", HOST_RD_VALID, tx_m.size() != 0);
    if (tx_m.size() != 0) chk("rd_byte", HOST_RD_BYTE, tx_m[0]);
    HOST_RD_EN = 1'b1;
    tick();
    HOST_RD_EN = 1'b0;
    if (tx_m.size() != 0) void'(tx_m.pop_front());
  endtask

  // Controller-style read: RD_N low for 'hold' cycles; optional host push on the pop cycle.
  task automatic pin_read(input int hold, input bit also_push, input logic [7:0] pb);
    bit         had;
    logic [7:0] exp;
    tick();
    chk("rxf_idle", usb_if.USB_RXF_N, rx_m.size() == 0);
    had = (rx_m.size() != 0);
    exp = had ? rx_m[0] : 8'h00;
    usb_if.USB_RD_N = 1'b0;
    tick();
    if (!had) perr_m = 1'b1;
    chk("dout", usb_if.USB_DATA_OUT, exp);
    chk("dout_en", usb_if.USB_DATA_OUT_EN, 1'b1);
    chk("rxf_drive", usb_if.USB_RXF_N, !had);
    chk("perr_rd", PROTO_ERR, perr_m);
    tick(hold - 1);
    chk("dout_hold", usb_if.USB_DATA_OUT, exp);
    usb_if.USB_RD_N = 1'b1;
    if (also_push) begin
      HOST_WR_EN = 1'b1;
      HOST_WR_BYTE = pb;
    end
    tick();
    HOST_WR_EN = 1'b0;
    if (had) begin
      void'(rx_m.pop_front());
      rdc_m++;
    end
    if (also_push && rx_m.size() < DEPTH) rx_m.push_back(pb);
    chk("dout_en_off", usb_if.USB_DATA_OUT_EN, 1'b0);
    chk("rxf_pre", usb_if.USB_RXF_N, 1'b1);
    for (int i = 1; i < PRE; i++) begin
      tick();
      chk("rxf_pre", usb_if.USB_RXF_N, 1'b1);
    end
    tick();
    chk("rxf_after", usb_if.USB_RXF_N, rx_m.size() == 0);
    chk_counts();
  endtask

  // Controller-style write of byte b with WR low for 'hold' cycles.
  task automatic pin_write(input logic [7:0] b, input int hold);
    bit ok;
    tick();
    chk("txe_idle", usb_if.USB_TXE_N, tx_m.size() == DEPTH);
    ok = (tx_m.size() < DEPTH);
    usb_if.USB_WR = 1'b0;
    usb_if.USB_DATA_IN = b;
    tick();
    if (ok) begin
      tx_m.push_back(b);
      wrc_m++;
    end else begin
      perr_m = 1'b1;
    end
    chk("txe_cap", usb_if.USB_TXE_N, 1'b1);
    chk("perr_wr", PROTO_ERR, perr_m);
    usb_if.USB_DATA_IN = 8'($urandom);
    tick(hold - 1);
    usb_if.USB_WR = 1'b1;
    tick();
    chk("txe_pre", usb_if.USB_TXE_N, 1'b1);
    for (int i = 1; i < PRE; i++) begin
      tick();
      chk("txe_pre", usb_if.USB_TXE_N, 1'b1);
    end
    tick();
    chk("txe_after", usb_if.USB_TXE_N, tx_m.size() == DEPTH);
    chk_counts();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    usb_if.USB_RD_N = 1'b1;
    usb_if.USB_WR = 1'b1;
    usb_if.USB_DATA_IN = 8'h00;
    #2;
    apply_reset();

    // Single byte host -> pin, RD_N held low 20 cycles.
    host_push(8'hA5);
    pin_read(20, 1'b0, 8'h00);

    // Single byte pin -> host.
    pin_write(8'h3C, 3);
    host_pop();
    host_pop();

    // Read strobe with RX empty.
    pin_read(3, 1'b0, 8'h00);
    chk("rx_unchanged", HOST_WR_READY, 1'b1);

    // Fill TX, force a 17th write, drain in order.
    apply_reset();
    for (int i = 0; i < DEPTH; i++) pin_write(8'(i), 2);
    pin_write(8'hEE, 2);
    chk("perr_tx_full", PROTO_ERR, 1'b1);
    for (int i = 0; i < DEPTH; i++) host_pop();
    host_pop();

    // Host push and pin pop in the same cycle with RX full.
    for (int i = 0; i < DEPTH; i++) host_push(8'h80 + 8'(i));
    chk("rx_full", HOST_WR_READY, 1'b0);
    pin_read(2, 1'b1, 8'hE0);
    chk("rx_still_full", HOST_WR_READY, 1'b0);
    for (int i = 0; i < DEPTH; i++) pin_read(2, 1'b0, 8'h00);

    // Random traffic mix.
    for (int i = 0; i < 120; i++) begin
      case ($urandom_range(0, 3))
        0: host_push(8'($urandom));
        1: pin_read($urandom_range(1, 6), ($urandom_range(0, 3) == 0), 8'($urandom));
        2: pin_write(8'($urandom), $urandom_range(1, 5));
        default: host_pop();
      endcase
    end
    chk("perr_random", PROTO_ERR, perr_m);

    // Reset while a read is being driven.
    while (rx_m.size() != 0) pin_read(1, 1'b0, 8'h00);
    pin_read(1, 1'b0, 8'h00);
    host_push(8'h5A);
    tick();
    usb_if.USB_RD_N = 1'b0;
    tick(3);
    chk("drive_en", usb_if.USB_DATA_OUT_EN, 1'b1);
    chk("drive_perr", PROTO_ERR, 1'b1);
    #2;
    apply_reset();
    chk("post_rst_valid", HOST_RD_VALID, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
